// File: rtl/mem_port_arbiter_rv.sv
// Sequences instruction fetch, data read and data write of one instruction onto a
// single valid/ready memory port, latching returned words and flagging access timeouts.
module mem_port_arbiter_rv #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwStart,
    input  logic [31:0] iwRead1Addr,
    input  logic        iwRead2En,
    input  logic [31:0] iwRead2Addr,
    input  logic [31:0] iwWriteAddr,
    input  logic [31:0] iwWriteData,
    input  logic [3:0]  iwWstrb,
    output logic [31:0] owRead1Data,
    output logic [31:0] owRead2Data,
    output logic        owDone,
    output logic        owBusy,
    output logic        owError,
    output logic [31:0] owMemAddr,
    output logic [31:0] owMemWData,
    output logic [3:0]  owMemWstrb,
    output logic        owMemValid,
    input  logic        iwMemReady,
    input  logic [31:0] iwMemRData
);

    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
    localparam bit          TMO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TMO_LAST   = TMO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DREAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] tmo_cnt, tmo_cnt_nxt;
    logic [31:0] rd1_nxt, rd2_nxt;
    logic        err_nxt;
    logic        expired;
    logic        write_req;

    assign write_req = (iwWstrb != 4'd0);
    assign expired   = TMO_EN && (tmo_cnt == TMO_LAST);

    // NOTE: every signal written here gets a default first so no latch is inferred
    // on paths that leave it untouched.
    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        rd1_nxt     = owRead1Data;
        rd2_nxt     = owRead2Data;
        err_nxt     = owError;

        case (state)
            S_IDLE: begin
                if (iwStart) begin
                    state_nxt   = S_FETCH;
                    tmo_cnt_nxt = 16'd0;
                end
            end
            S_FETCH: begin
                if (iwMemReady) begin
                    rd1_nxt     = iwMemRData;
                    tmo_cnt_nxt = 16'd0;
                    if (iwRead2En)      state_nxt = S_DREAD;
                    else if (write_req) state_nxt = S_WRITE;
                    else                state_nxt = S_DONE;
                end else if (expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
            end
            S_DREAD: begin
                if (iwMemReady) begin
                    rd2_nxt     = iwMemRData;
                    tmo_cnt_nxt = 16'd0;
                    state_nxt   = write_req ? S_WRITE : S_DONE;
                end else if (expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
            end
            S_WRITE: begin
                if (iwMemReady) begin
                    state_nxt = S_DONE;
                end else if (expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // from the same pre-edge values.
    always_ff @(posedge iwClk) begin
        if (!iwnRst) begin
            state       <= S_IDLE;
            tmo_cnt     <= 16'd0;
            owRead1Data <= NOP_INSN;
            owRead2Data <= 32'd0;
            owError     <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            owRead1Data <= rd1_nxt;
            owRead2Data <= rd2_nxt;
            owError     <= err_nxt;
        end
    end

    // Bus side follows the live core inputs; the core keeps them stable while busy.
    always_comb begin
        owMemAddr  = 32'd0;
        owMemWData = 32'd0;
        owMemWstrb = 4'd0;
        owMemValid = 1'b0;
        case (state)
            S_FETCH: begin
                owMemAddr  = iwRead1Addr;
                owMemValid = 1'b1;
            end
            S_DREAD: begin
                owMemAddr  = {iwRead2Addr[31:2], 2'b00};
                owMemValid = 1'b1;
            end
            S_WRITE: begin
                owMemAddr  = iwWriteAddr;
                owMemWData = iwWriteData;
                owMemWstrb = iwWstrb;
                owMemValid = 1'b1;
            end
            default: ;
        endcase
    end

    assign owDone = (state == S_DONE);
    assign owBusy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter_rv.sv
// Self-checking bench for mem_port_arbiter_rv: directed scenarios plus randomized
// transactions compared cycle by cycle against a phase-list model of the bus.
module tb_mem_port_arbiter_rv;

    localparam int TMO = 4;

    logic        iwClk = 1'b0;
    logic        iwnRst;
    logic        iwStart;
    logic [31:0] iwRead1Addr;
    logic        iwRead2En;
    logic [31:0] iwRead2Addr;
    logic [31:0] iwWriteAddr;
    logic [31:0] iwWriteData;
    logic [3:0]  iwWstrb;
    logic [31:0] owRead1Data;
    logic [31:0] owRead2Data;
    logic        owDone;
    logic        owBusy;
    logic        owError;
    logic [31:0] owMemAddr;
    logic [31:0] owMemWData;
    logic [3:0]  owMemWstrb;
    logic        owMemValid;
    logic        iwMemReady;
    logic [31:0] iwMemRData;

    mem_port_arbiter_rv #(.TIMEOUT_CYCLES(TMO)) dut (
        .iwClk       (iwClk),
        .iwnRst      (iwnRst),
        .iwStart     (iwStart),
        .iwRead1Addr (iwRead1Addr),
        .iwRead2En   (iwRead2En),
        .iwRead2Addr (iwRead2Addr),
        .iwWriteAddr (iwWriteAddr),
        .iwWriteData (iwWriteData),
        .iwWstrb     (iwWstrb),
        .owRead1Data (owRead1Data),
        .owRead2Data (owRead2Data),
        .owDone      (owDone),
        .owBusy      (owBusy),
        .owError     (owError),
        .owMemAddr   (owMemAddr),
        .owMemWData  (owMemWData),
        .owMemWstrb  (owMemWstrb),
        .owMemValid  (owMemValid),
        .iwMemReady  (iwMemReady),
        .iwMemRData  (iwMemRData)
    );

    always #5 iwClk = ~iwClk;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the core should see in the data registers and error flag.
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 32'(owMemValid), 32'd0);
        check({tag, ".busy"},  32'(owBusy),     32'd0);
        check({tag, ".done"},  32'(owDone),     32'd0);
        check({tag, ".addr"},  owMemAddr,       32'd0);
        check({tag, ".wstrb"}, 32'(owMemWstrb), 32'd0);
        check({tag, ".wdata"}, owMemWData,      32'd0);
        check({tag, ".r1"},    owRead1Data,     exp_r1);
        check({tag, ".r2"},    owRead2Data,     exp_r2);
        check({tag, ".err"},   32'(owError),    32'(exp_err));
    endtask

    // One transaction set. dly[k] is how many cycles phase k waits before ready;
    // a wait of TMO or more means the phase is aborted by the timeout.
    task automatic run_txn(input string tag,
                           input logic [31:0] a1, input logic en2, input logic [31:0] a2,
                           input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                           input int d_fetch, input int d_dread, input int d_write);
        int          kind_q[$];
        int          dly_q[$];
        bit          aborted;
        logic [31:0] rd;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;

        kind_q.push_back(0); dly_q.push_back(d_fetch);
        if (en2)       begin kind_q.push_back(1); dly_q.push_back(d_dread); end
        if (ws != 4'd0) begin kind_q.push_back(2); dly_q.push_back(d_write); end

        @(negedge iwClk);
        iwRead1Addr = a1; iwRead2En = en2; iwRead2Addr = a2;
        iwWriteAddr = wa; iwWriteData = wd; iwWstrb = ws;
        iwStart = 1'b1; iwMemReady = 1'b0;
        @(negedge iwClk);
        iwStart = 1'b0;
        aborted = 1'b0;

        foreach (kind_q[p]) begin
            if (aborted) break;
            case (kind_q[p])
                0:       begin e_addr = a1;            e_wdata = 32'd0; e_wstrb = 4'd0; end
                1:       begin e_addr = a2 & ~32'h3;   e_wdata = 32'd0; e_wstrb = 4'd0; end
                default: begin e_addr = wa;            e_wdata = wd;    e_wstrb = ws;   end
            endcase
            for (int w = 0; w <= TMO + 8; w++) begin
                check({tag, ".ph.valid"}, 32'(owMemValid), 32'd1);
                check({tag, ".ph.busy"},  32'(owBusy),     32'd1);
                check({tag, ".ph.done"},  32'(owDone),     32'd0);
                check({tag, ".ph.addr"},  owMemAddr,       e_addr);
                check({tag, ".ph.wstrb"}, 32'(owMemWstrb), 32'(e_wstrb));
                check({tag, ".ph.wdata"}, owMemWData,      e_wdata);
                rd = $urandom;
                iwMemRData = rd;
                if (w == dly_q[p]) begin
                    iwMemReady = 1'b1;
                    if (kind_q[p] == 0) exp_r1 = rd;
                    if (kind_q[p] == 1) exp_r2 = rd;
                    @(negedge iwClk);
                    break;
                end
                iwMemReady = 1'b0;
                if (w == TMO - 1) begin
                    exp_err = 1'b1;
                    aborted = 1'b1;
                    @(negedge iwClk);
                    break;
                end
                @(negedge iwClk);
            end
        end

        check({tag, ".done.pulse"}, 32'(owDone),     32'd1);
        check({tag, ".done.busy"},  32'(owBusy),     32'd1);
        check({tag, ".done.valid"}, 32'(owMemValid), 32'd0);
        check({tag, ".done.r1"},    owRead1Data,     exp_r1);
        check({tag, ".done.r2"},    owRead2Data,     exp_r2);
        check({tag, ".done.err"},   32'(owError),    32'(exp_err));
        // Start and ready are both ignored in DONE.
        iwStart    = 1'b1;
        iwMemReady = 1'b1;
        iwMemRData = $urandom;
        @(negedge iwClk);
        iwStart    = 1'b0;
        iwMemReady = 1'b0;
        check_idle({tag, ".after"});
    endtask

    initial begin
        iwnRst = 1'b0; iwStart = 1'b0; iwRead1Addr = '0; iwRead2En = 1'b0;
        iwRead2Addr = '0; iwWriteAddr = '0; iwWriteData = '0; iwWstrb = '0;
        iwMemReady = 1'b0; iwMemRData = '0;
        exp_r1 = 32'h0000_0013; exp_r2 = 32'd0; exp_err = 1'b0;

        // Reset then idle, with ready pulses that must be ignored.
        repeat (2) @(negedge iwClk);
        iwnRst = 1'b1;
        check_idle("reset");
        for (int i = 0; i < 4; i++) begin
            iwMemReady = ~iwMemReady;
            iwMemRData = $urandom;
            @(negedge iwClk);
            check_idle("idle_ready");
        end
        iwMemReady = 1'b0;

        // Full set with ready always high.
        run_txn("full", 32'h100, 1'b1, 32'h207, 32'h302, 32'hA5A5, 4'b0011, 0, 0, 0);
        // Fetch wait states: ready on the last cycle before expiry still completes.
        run_txn("wait3", 32'h100, 1'b1, 32'h207, 32'h302, 32'hA5A5, 4'b0011, 3, 0, 0);
        // Fetch-only.
        run_txn("fetch_only", 32'h440, 1'b0, 32'h555, 32'h666, 32'h1234, 4'b0000, 0, 0, 0);
        // Timeout in DREAD skips WRITE and sets the sticky error.
        run_txn("tmo_dread", 32'h100, 1'b1, 32'h207, 32'h302, 32'hA5A5, 4'b0011, 1, 20, 0);
        // Error does not block the next transaction.
        run_txn("after_tmo", 32'h800, 1'b1, 32'h90B, 32'hA00, 32'hBEEF, 4'b1111, 0, 2, 1);

        // Reset while WRITE waits for ready.
        @(negedge iwClk);
        iwRead1Addr = 32'h10; iwRead2En = 1'b1; iwRead2Addr = 32'h20;
        iwWriteAddr = 32'h30; iwWriteData = 32'h55; iwWstrb = 4'b1000;
        iwStart = 1'b1; iwMemReady = 1'b1; iwMemRData = 32'hCAFE_0001;
        @(negedge iwClk);
        iwStart = 1'b0;
        check("rst_mid.fetch_addr", owMemAddr, 32'h10);
        @(negedge iwClk);
        check("rst_mid.dread_addr", owMemAddr, 32'h20);
        @(negedge iwClk);
        check("rst_mid.write_strb", 32'(owMemWstrb), 32'h8);
        iwMemReady = 1'b0;
        iwnRst = 1'b0;
        @(negedge iwClk);
        iwnRst = 1'b1;
        exp_r1 = 32'h0000_0013; exp_r2 = 32'd0; exp_err = 1'b0;
        check_idle("rst_mid");
        @(negedge iwClk);
        check_idle("rst_mid.next");

        // Randomized transactions; waits of TMO or more exercise the abort path.
        for (int t = 0; t < 40; t++) begin
            logic [3:0] ws;
            ws = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            run_txn("rand", $urandom, 1'($urandom), $urandom, $urandom, $urandom, ws,
                    $urandom_range(0, TMO), $urandom_range(0, TMO), $urandom_range(0, TMO));
            if ($urandom_range(0, 3) == 0) begin
                iwMemReady = 1'b1;
                iwMemRData = $urandom;
                @(negedge iwClk);
                iwMemReady = 1'b0;
                check_idle("rand_gap");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter_rv.md
Name: mem_port_arbiter_rv

Overview:
Sequences the core's three memory ports onto one external single-port memory with a valid/ready handshake. The three ports are instruction fetch, data read and data write. The block sits directly downstream of the single-cycle RISC-V control core, between the core and the memory/bus. For each instruction it performs fetch, then an optional data read, then an optional write. It holds the returned data in registers and reports completion and busy status so the core can gate its PC and register-write updates.

Parameters:
TIMEOUT_CYCLES, 255, max cycles an access waits for iwMemReady before abort; 0 disables timeout; legal range 0..65535.

Ports:
iwClk  input  1  clock; all state updates on rising edge
iwnRst  input  1  synchronous active-low reset, sampled on rising edge of iwClk
iwStart  input  1  begin one transaction set; honoured only in IDLE
iwRead1Addr  input  32  instruction fetch address
iwRead2En  input  1  data read required this transaction
iwRead2Addr  input  32  data read address; bits [1:0] forced to 0 on bus
iwWriteAddr  input  32  data write address, passed unmodified
iwWriteData  input  32  data write value
iwWstrb  input  4  byte strobes; 0 means no write phase
owRead1Data  output  32  registered fetched instruction
owRead2Data  output  32  registered data-read word
owDone  output  1  one-cycle pulse when a transaction set ends, including on abort
owBusy  output  1  high whenever state is not IDLE
owError  output  1  sticky timeout flag; cleared only by reset
owMemAddr  output  32  bus address
owMemWData  output  32  bus write data
owMemWstrb  output  4  bus strobes; 0 for reads
owMemValid  output  1  bus request
iwMemReady  input  1  bus accept/complete; ignored while owMemValid is low
iwMemRData  input  32  bus read data, valid in a cycle where iwMemReady is high

Behaviour:
- States: IDLE, FETCH, DREAD, WRITE, DONE. Encoding is free.
- Reset on a rising edge with iwnRst=0, including mid-transaction:
  - state=IDLE
  - owRead1Data=32'h00000013 (normalized NOP), owRead2Data=0
  - owError=0, timeout counter=0
  - all bus outputs 0; owDone=0, owBusy=0
  - No pending bus access is completed or remembered.
- IDLE -> FETCH when iwStart=1. Otherwise stay in IDLE.
- Bus outputs are combinational from state and the live iw* inputs. The core holds its inputs stable while owBusy=1.
  - FETCH: owMemAddr=iwRead1Addr, owMemWstrb=0.
  - DREAD: owMemAddr={iwRead2Addr[31:2],2'b00}, owMemWstrb=0.
  - WRITE: owMemAddr=iwWriteAddr, owMemWData=iwWriteData, owMemWstrb=iwWstrb.
  - owMemValid=1 exactly in FETCH, DREAD and WRITE.
  - owMemWData=0 outside WRITE.
- Access completes on a rising edge where owMemValid=1 and iwMemReady=1.
  - FETCH completes: owRead1Data<=iwMemRData. Next state is DREAD if iwRead2En, else WRITE if iwWstrb!=0, else DONE.
  - DREAD completes: owRead2Data<=iwMemRData. Next state is WRITE if iwWstrb!=0, else DONE.
  - WRITE completes: next state is DONE.
- Back-to-back accesses are allowed: owMemValid stays high across phases while the address changes.
- DONE: owDone=1 for exactly one cycle, then IDLE. iwStart is ignored in DONE and in all busy states.
- Latency with iwMemReady tied to 1 and all phases enabled:
  - start sampled at edge E0
  - FETCH in cycle 1, DREAD in cycle 2, WRITE in cycle 3
  - DONE in cycle 4; IDLE again in cycle 5
- Fetch-only transaction: owDone is high in cycle 2.
- Timeout:
  - A 16-bit counter clears on entering each access state and increments each cycle the access is not completed.
  - If TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1 on an edge without ready: owError<=1, go to DONE.
  - The aborted phase leaves its data register unchanged; remaining phases are skipped.
  - Ready arriving on the same edge as expiry counts as completion, not timeout.
- owError does not block later transactions.

Test Plan:
- Reset then idle: iwnRst low for 2 cycles -> owRead1Data=32'h00000013, owRead2Data=0, owMemValid=0, owBusy=0, owError=0; iwMemReady pulses while idle change nothing.
- Full set, ready=1: start with Read1Addr=0x100, Read2En=1, Read2Addr=0x207, Wstrb=4'b0011, WriteAddr=0x302, WriteData=0xA5A5 -> bus addrs 0x100, 0x204, 0x302 in cycles 1-3 with strobe 0011 only in cycle 3; owDone in cycle 4; data regs hold returned words.
- Wait states: ready delayed 3 cycles in FETCH -> addr 0x100 and owMemValid held stable 4 cycles; DREAD follows the cycle after acceptance.
- Fetch-only: Read2En=0, Wstrb=0 -> one bus access, owDone in cycle 2, owRead2Data unchanged.
- Timeout: TIMEOUT_CYCLES=4, ready never asserted in DREAD -> 4 cycles of valid, then DONE pulse, owError=1 until reset, WRITE skipped, owRead2Data unchanged; next start proceeds normally.
- Reset mid-WRITE with ready low: iwnRst=0 one edge -> IDLE next cycle, owMemValid=0, registers at reset values, no owDone.
